// File: rtl/bsg_launch_sync_sync_arb.sv
// Launch-side sequencer and round-robin arbiter for a bsg_launch_sync_sync
// crossing. Each granted word is held stable on launch_data_o, the toggle is
// flipped settle_p cycles later, and the word stays put for hold_p more cycles
// so the far domain can sample it on the toggle edge without tearing.
module bsg_launch_sync_sync_arb #(
  parameter int unsigned width_p  = 64,
  parameter int unsigned els_p    = 4,
  parameter int unsigned settle_p = 1,
  parameter int unsigned hold_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         en_i,
  input  logic [els_p-1:0]             v_i,
  input  logic [els_p*width_p-1:0]     data_i,
  output logic [els_p-1:0]             yumi_o,
  output logic [width_p-1:0]           launch_data_o,
  output logic [$clog2(els_p)-1:0]     launch_id_o,
  output logic                         launch_toggle_o,
  output logic                         busy_o
);

  localparam int unsigned ID_W    = $clog2(els_p);
  localparam int unsigned CNT_MAX = (settle_p > hold_p) ? settle_p : hold_p;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e               state_r, state_n;
  logic [CNT_W-1:0]     cnt_r, cnt_n;
  logic [ID_W-1:0]      last_r, last_n;
  logic [width_p-1:0]   data_n;
  logic [ID_W-1:0]      id_n;
  logic                 tog_n;
  logic                 busy_n;

  logic                 grant_v;
  logic [ID_W-1:0]      grant_id;
  int unsigned          idx;

  logic [width_p-1:0]   data_a [els_p];

  // Unpack the flat requester data bus into one word per requester.
  for (genvar k = 0; k < els_p; k++) begin : g_unpack
    assign data_a[k] = data_i[k*width_p +: width_p];
  end

  // Round-robin search: first valid requester after last_r, wrapping.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int unsigned i = 1; i <= els_p; i++) begin
      idx = (32'(last_r) + i) % els_p;
      if (!grant_v && v_i[ID_W'(idx)]) begin
        grant_v  = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end

  // Next-state, counter and launch-register update; yumi_o only in IDLE.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    last_n  = last_r;
    data_n  = launch_data_o;
    id_n    = launch_id_o;
    tog_n   = launch_toggle_o;
    yumi_o  = '0;

    unique case (state_r)
      IDLE: begin
        // Reset is folded in so no accept leaks out while the block is held.
        if (reset_n_i && en_i && grant_v) begin
          yumi_o[grant_id] = 1'b1;
          data_n  = data_a[grant_id];
          id_n    = grant_id;
          last_n  = grant_id;
          cnt_n   = CNT_W'(settle_p - 1);
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_r == '0) begin
          tog_n   = ~launch_toggle_o;
          cnt_n   = CNT_W'(hold_p - 1);
          state_n = HOLD;
        end else begin
          cnt_n = cnt_r - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_r == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and launch registers; reset drops any in-flight word.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r         <= IDLE;
      cnt_r           <= '0;
      last_r          <= ID_W'(els_p - 1);
      launch_data_o   <= '0;
      launch_id_o     <= '0;
      launch_toggle_o <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state_r         <= state_n;
      cnt_r           <= cnt_n;
      last_r          <= last_n;
      launch_data_o   <= data_n;
      launch_id_o     <= id_n;
      launch_toggle_o <= tog_n;
      busy_o          <= busy_n;
    end
  end

endmodule

// File: tb/tb_bsg_launch_sync_sync_arb.sv
// Directed bench for bsg_launch_sync_sync_arb (width 64, 4 requesters,
// settle 1, hold 4, so one word every 6 cycles).
module tb_bsg_launch_sync_sync_arb;

  localparam int W = 64;
  localparam int N = 4;

  logic           clk;
  logic           reset_n;
  logic           en;
  logic [N-1:0]   v;
  logic [N*W-1:0] data;
  logic [N-1:0]   yumi;
  logic [W-1:0]   launch_data;
  logic [1:0]     launch_id;
  logic           launch_toggle;
  logic           busy;

  logic [W-1:0]   dat [N];
  int             n_checks;
  int             n_errors;
  logic           exp_tog;

  bsg_launch_sync_sync_arb #(
    .width_p (W),
    .els_p   (N),
    .settle_p(1),
    .hold_p  (4)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .en_i           (en),
    .v_i            (v),
    .data_i         (data),
    .yumi_o         (yumi),
    .launch_data_o  (launch_data),
    .launch_id_o    (launch_id),
    .launch_toggle_o(launch_toggle),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    data = '0;
    for (int k = 0; k < N; k++) data[k*W +: W] = dat[k];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until the block reports idle, bounded so a stuck FSM cannot hang the run.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq("idle_wait", 64'(busy), 64'd0);
  endtask

  initial begin
    int k, r, eid, flips;
    logic [3:0]  ey;
    logic [63:0] edat;

    n_checks = 0;
    n_errors = 0;
    dat[0] = 64'h1111_0000_0000_0000;
    dat[1] = 64'h2222_0000_0000_0001;
    dat[2] = 64'hDEADBEEF_01234567;
    dat[3] = 64'h4444_0000_0000_0003;

    // Reset held with all requesters valid: nothing accepted, outputs cleared.
    reset_n = 1'b0;
    en      = 1'b1;
    v       = 4'hF;
    #12;
    check_eq("rst_yumi",   64'(yumi), 64'd0);
    check_eq("rst_data",   launch_data, 64'd0);
    check_eq("rst_id",     64'(launch_id), 64'd0);
    check_eq("rst_toggle", 64'(launch_toggle), 64'd0);
    check_eq("rst_busy",   64'(busy), 64'd0);
    #10;
    reset_n = 1'b1;

    // All four valid: grants 0,1,2,3,0 at cycles 0,6,12,18,24.
    for (int c = 0; c <= 25; c++) begin
      if (c > 0) tick();
      if (c == 25) v = 4'h0;
      #1;
      k = c / 6;
      r = c % 6;
      ey = (r == 0 && c < 25) ? 4'(1 << (k % 4)) : 4'h0;
      if (c == 0) begin
        eid  = 0;
        edat = 64'd0;
      end else begin
        eid  = (r >= 1) ? (k % 4) : ((k - 1) % 4);
        edat = dat[eid];
      end
      flips = (r >= 2) ? k + 1 : k;
      check_eq($sformatf("rr_yumi_c%0d", c),   64'(yumi), 64'(ey));
      check_eq($sformatf("rr_id_c%0d", c),     64'(launch_id), 64'(eid));
      check_eq($sformatf("rr_data_c%0d", c),   launch_data, edat);
      check_eq($sformatf("rr_toggle_c%0d", c), 64'(launch_toggle), 64'(flips % 2));
      check_eq($sformatf("rr_busy_c%0d", c),   64'(busy), 64'(r != 0));
    end
    exp_tog = 1'b1;

    // Single request from requester 2; check the exact per-cycle timing.
    wait_idle();
    v = 4'b0100;
    #1;
    check_eq("t2_yumi", 64'(yumi), 64'h4);
    for (int c = 1; c <= 6; c++) begin
      tick();
      v = 4'h0;
      #1;
      if (c == 1) begin
        check_eq("t2_data",    launch_data, 64'hDEADBEEF_01234567);
        check_eq("t2_id",      64'(launch_id), 64'd2);
        check_eq("t2_tog_c1",  64'(launch_toggle), 64'(exp_tog));
        check_eq("t2_busy_c1", 64'(busy), 64'd1);
      end
      if (c == 2) begin
        exp_tog = ~exp_tog;
        check_eq("t2_tog_c2", 64'(launch_toggle), 64'(exp_tog));
      end
      if (c == 5) check_eq("t2_busy_c5", 64'(busy), 64'd1);
      if (c == 6) begin
        check_eq("t2_busy_c6", 64'(busy), 64'd0);
        check_eq("t2_hold",    launch_data, 64'hDEADBEEF_01234567);
      end
    end

    // Pointer wrap: grant 3, then {0,3} valid gives 0 then 3.
    wait_idle();
    v = 4'b1000;
    #1;
    check_eq("t4_yumi3", 64'(yumi), 64'h8);
    exp_tog = ~exp_tog;
    tick();
    v = 4'h0;
    wait_idle();
    v = 4'b1001;
    #1;
    check_eq("t4_wrap0", 64'(yumi), 64'h1);
    exp_tog = ~exp_tog;
    tick();
    v = 4'b1000;
    #1;
    check_eq("t4_no_yumi_busy", 64'(yumi), 64'h0);
    wait_idle();
    #1;
    check_eq("t4_then3", 64'(yumi), 64'h8);
    exp_tog = ~exp_tog;
    tick();
    v = 4'h0;
    #1;
    check_eq("t4_id3", 64'(launch_id), 64'd3);

    // en dropped mid-transfer: the word still completes; no grants until en returns.
    wait_idle();
    v = 4'b0010;
    #1;
    check_eq("t5_yumi", 64'(yumi), 64'h2);
    exp_tog = ~exp_tog;
    tick();
    v = 4'h0;
    tick();
    en = 1'b0;
    wait_idle();
    check_eq("t5_toggle", 64'(launch_toggle), 64'(exp_tog));
    check_eq("t5_id",     64'(launch_id), 64'd1);
    v = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("t5_gated_yumi_%0d", c), 64'(yumi), 64'h0);
      check_eq($sformatf("t5_gated_busy_%0d", c), 64'(busy), 64'h0);
      tick();
    end
    en = 1'b1;
    #1;
    check_eq("t5_regrant", 64'(yumi), 64'h2);

    // Reset pulse during SETTLE: outputs clear at once, toggle never flips.
    tick();
    v = 4'h0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_data",   launch_data, 64'd0);
    check_eq("t6_id",     64'(launch_id), 64'd0);
    check_eq("t6_toggle", 64'(launch_toggle), 64'd0);
    check_eq("t6_busy",   64'(busy), 64'd0);
    check_eq("t6_yumi",   64'(yumi), 64'd0);
    #2;
    reset_n = 1'b1;
    tick();
    #1;
    check_eq("t6_post_toggle", 64'(launch_toggle), 64'd0);
    check_eq("t6_post_busy",   64'(busy), 64'd0);
    v = 4'hF;
    #1;
    check_eq("t6_prio0", 64'(yumi), 64'h1);
    tick();
    v = 4'h0;
    #1;
    check_eq("t6_id0",   64'(launch_id), 64'd0);
    check_eq("t6_data0", launch_data, dat[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
